lfsr_prbs_checker: RTL

//  Receive-side companion to the LFSR_<N>BITS generators. Self-synchronises to an

---
 rtl/lfsr_pkg.sv | 24 ++
 rtl/lfsr_popcount.sv | 18 +
 rtl/lfsr_prbs_checker.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions for the PRBS generators and checker: tap masks,
// the one-shift Fibonacci step, and the checker's state encoding.
package lfsr_pkg;

  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam int unsigned LFSR_MAX_W   = 16;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // Narrower LFSRs are zero-extended in and truncated on the way out; the
  // feedback bit lands in bit 0 and the shifted-out MSB is discarded.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_next(
    input logic [LFSR_MAX_W-1:0] state,
    input logic [LFSR_MAX_W-1:0] taps
  );
    return {state[LFSR_MAX_W-2:0], ^(state & taps)};
  endfunction

endpackage

// File: rtl/lfsr_popcount.sv
// Combinational population count, used to size bit errors in one received word.
module lfsr_popcount #(
  parameter int N = 16
) (
  input  logic [N-1:0]             data,
  output logic [$clog2(N+1)-1:0]   count
);

  localparam int PW = $clog2(N+1);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + PW'(data[i]);
    end
  end

endmodule

// File: rtl/lfsr_prbs_checker.sv
// Self-synchronising PRBS checker: seeds from the received stream, flywheels
// once locked, and counts errored words and bits with saturating counters.
module lfsr_prbs_checker
  import lfsr_pkg::*;
#(
  parameter int             N        = 16,
  parameter logic [N-1:0]   TAPS     = 16'hB400,
  parameter int             LOCK_CNT = 8,
  parameter int             LOSS_CNT = 4,
  parameter int             CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [N-1:0]     in_data,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_word_cnt,
  output logic [CNT_W-1:0] err_bit_cnt,
  output logic [1:0]       state
);

  // in_valid qualifies in_data for exactly one cycle; there is no backpressure,
  // so every cycle with in_valid=1 consumes one word and nothing else advances.

  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int LW = $clog2(LOSS_CNT + 1);
  localparam int PW = $clog2(N + 1);

  chk_state_e       state_q, state_d;
  logic [N-1:0]     pred_q, pred_d;
  logic [MW-1:0]    match_q, match_d;
  logic [LW-1:0]    miss_q, miss_d;
  logic             locked_q, locked_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0] bcnt_q, bcnt_d;

  logic [N-1:0]     diff;
  logic [PW-1:0]    err_bits;
  logic [CNT_W:0]   wsum;
  logic [CNT_W:0]   bsum;
  logic             mismatch;

  function automatic logic [N-1:0] next_of(input logic [N-1:0] s);
    return N'(lfsr_next(LFSR_MAX_W'(s), LFSR_MAX_W'(TAPS)));
  endfunction

  assign diff     = in_data ^ pred_q;
  assign mismatch = (diff != '0);

  lfsr_popcount #(.N(N)) u_popcount (
    .data  (diff),
    .count (err_bits)
  );

  // One extra carry bit detects overflow so the counters pin at all-ones.
  assign wsum = {1'b0, wcnt_q} + (CNT_W+1)'(1);
  assign bsum = {1'b0, bcnt_q} + (CNT_W+1)'(err_bits);

  always_comb begin
    state_d  = state_q;
    pred_d   = pred_q;
    match_d  = match_q;
    miss_d   = miss_q;
    locked_d = locked_q;
    pulse_d  = 1'b0;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;

    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (in_data != '0) begin
            pred_d  = next_of(in_data);
            match_d = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (!mismatch) begin
            pred_d  = next_of(in_data);
            match_d = match_q + MW'(1);
            if (int'(match_q) + 1 == LOCK_CNT) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
              miss_d   = '0;
            end
          end else if (in_data == '0) begin
            match_d = '0;
            state_d = SEARCH;
          end else begin
            pred_d  = next_of(in_data);
            match_d = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances from our own copy, never from the wire.
          pred_d = next_of(pred_q);
          if (mismatch) begin
            pulse_d = 1'b1;
            wcnt_d  = wsum[CNT_W] ? '1 : wsum[CNT_W-1:0];
            bcnt_d  = bsum[CNT_W] ? '1 : bsum[CNT_W-1:0];
            miss_d  = miss_q + LW'(1);
            if (int'(miss_q) + 1 == LOSS_CNT) begin
              state_d  = SEARCH;
              locked_d = 1'b0;
              miss_d   = '0;
              match_d  = '0;
            end
          end else begin
            miss_d = '0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    if (clear_cnt) begin
      wcnt_d = '0;
      bcnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SEARCH;
      pred_q   <= '0;
      match_q  <= '0;
      miss_q   <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      pred_q   <= pred_d;
      match_q  <= match_d;
      miss_q   <= miss_d;
      locked_q <= locked_d;
      pulse_q  <= pulse_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
    end
  end

  assign locked       = locked_q;
  assign err_pulse    = pulse_q;
  assign err_word_cnt = wcnt_q;
  assign err_bit_cnt  = bcnt_q;
  assign state        = state_q;

endmodule
